// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared constants for the sudoku display path
package sudoku_pkg;

  localparam int NUM_CELLS = 4;
  localparam int CELL_W    = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef logic [CELL_W-1:0] cellT;

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - 4-bit cell value to active-low {g,f,e,d,c,b,a} glyph
module hex_to_seg
  import sudoku_pkg::*;
(
  input  cellT       value,
  output logic [6:0] seg
);

  // Zero is an empty sudoku cell, so it renders blank rather than as "0".
  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'h0: seg = SEG_BLANK;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sudoku_display_driver.sv
// rtl/sudoku_display_driver.sv - 4-digit multiplexed seven-segment driver with blink and deny dash
module sudoku_display_driver
  import sudoku_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000,
  parameter int DENY_LEN  = 25000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] currentRow,
  input  logic [3:0]  currentNum,
  input  logic        denyPulse,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int DW = $clog2(DENY_LEN);
  localparam int IW = $clog2(NUM_CELLS);

  logic [SW-1:0]          scanCnt;
  logic [BW-1:0]          blinkCnt;
  logic [DW-1:0]          denyCnt;
  logic [IW-1:0]          digit;
  logic                   blinkOn;
  logic [15:0]            rowSnap;
  logic [NUM_CELLS-1:0]   selSnap;

  logic                   slotTick;
  logic                   denyActive;
  cellT                   cellVal;
  logic [6:0]             hexGlyph;
  logic [6:0]             glyph;

  assign slotTick   = (scanCnt == SW'(SCAN_DIV - 1));
  assign denyActive = denyPulse || (denyCnt != '0);
  assign cellVal    = rowSnap[CELL_W*digit +: CELL_W];

  hex_to_seg uHex (
    .value (cellVal),
    .seg   (hexGlyph)
  );

  // Deny outranks the blink-off phase so a rejected write is always visible.
  always_comb begin
    glyph = hexGlyph;
    if (selSnap[digit] && denyActive) begin
      glyph = SEG_DASH;
    end else if (selSnap[digit] && !blinkOn) begin
      glyph = SEG_BLANK;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      scanCnt  <= '0;
      blinkCnt <= '0;
      denyCnt  <= '0;
      digit    <= '0;
      blinkOn  <= 1'b1;
      rowSnap  <= '0;
      selSnap  <= '0;
      seg      <= SEG_BLANK;
      an       <= 4'hF;
    end else begin
      if (slotTick) begin
        scanCnt <= '0;
        digit   <= digit + 1'b1;
        seg     <= glyph;
        an      <= ~(NUM_CELLS'(1) << digit);
        // Snapshot only at the frame boundary so a scan never mixes two rows.
        if (digit == IW'(NUM_CELLS - 1)) begin
          rowSnap <= currentRow;
          selSnap <= currentNum;
        end
      end else begin
        scanCnt <= scanCnt + 1'b1;
      end

      if (blinkCnt == BW'(BLINK_DIV - 1)) begin
        blinkCnt <= '0;
        blinkOn  <= ~blinkOn;
      end else begin
        blinkCnt <= blinkCnt + 1'b1;
      end

      if (denyPulse) begin
        denyCnt <= DW'(DENY_LEN - 1);
      end else if (denyCnt != '0) begin
        denyCnt <= denyCnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sudoku_display_driver.sv
// tb/tb_sudoku_display_driver.sv - self-checking bench for sudoku_display_driver
module tb_sudoku_display_driver;

  localparam int SCAN  = 4;
  localparam int BLINK = 16;
  localparam int DENY  = 32;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] currentRow = '0;
  logic [3:0]  currentNum = '0;
  logic        denyPulse = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int fails  = 0;

  sudoku_display_driver #(
    .SCAN_DIV  (SCAN),
    .BLINK_DIV (BLINK),
    .DENY_LEN  (DENY)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .currentRow (currentRow),
    .currentNum (currentNum),
    .denyPulse  (denyPulse),
    .seg        (seg),
    .an         (an)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] refGlyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h7F;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Model works from the cycle count since reset release: slot, digit and
  // blink phase are plain divisions of it; deny is "within DENY of last pulse".
  int          cyc;
  int          lastDeny;
  int          md;
  logic        mBlinkVis;
  logic        mDeny;
  logic [15:0] mRow;
  logic [3:0]  mSel;
  logic [6:0]  expSeg;
  logic [3:0]  expAn;

  always @(posedge CLK) begin
    if (RST) begin
      cyc = 0; lastDeny = -1; mRow = '0; mSel = '0;
      expSeg = 7'h7F; expAn = 4'hF;
    end else begin
      md        = (cyc / SCAN) % 4;
      mBlinkVis = ((cyc / BLINK) % 2) == 0;
      if (denyPulse) lastDeny = cyc;
      mDeny = (lastDeny >= 0) && ((cyc - lastDeny) < DENY);
      if ((cyc % SCAN) == SCAN - 1) begin
        if (mSel[md] && mDeny)           expSeg = 7'h3F;
        else if (mSel[md] && !mBlinkVis) expSeg = 7'h7F;
        else                             expSeg = refGlyph(mRow[4*md +: 4]);
        expAn = ~(4'b0001 << md);
        if (md == 3) begin
          mRow = currentRow;
          mSel = currentNum;
        end
      end
      cyc++;
    end
  end

  always @(negedge CLK) begin
    checks++;
    if (seg !== expSeg || an !== expAn) begin
      fails++;
      $display("FAIL model_cmp t=%0t seg=%h expected %h an=%b expected %b", $time, seg, expSeg, an, expAn);
    end
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got %h expected %h", nm, act, req);
    end
  endtask

  task automatic waitSlot(input logic [3:0] target);
    logic [3:0] prev;
    bit found;
    prev = an;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge CLK);
      if (an == target && prev != target) found = 1;
      prev = an;
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL waitSlot timeout an=%b expected %b", an, target);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  int dashCount;

  initial begin
    // Reset and scan order
    ticks(3);
    check("rst_seg", {1'b0, seg}, 8'h7F);
    check("rst_an", {4'h0, an}, 8'h0F);
    RST = 1'b0;
    ticks(3);  check("pre_tick_an", {4'h0, an}, 8'h0F);
    ticks(1);  check("an_d0", {4'h0, an}, 8'h0E);  check("seg_d0_blank", {1'b0, seg}, 8'h7F);
    ticks(4);  check("an_d1", {4'h0, an}, 8'h0D);
    ticks(4);  check("an_d2", {4'h0, an}, 8'h0B);
    ticks(4);  check("an_d3", {4'h0, an}, 8'h07);

    // Row display
    currentRow = 16'h4321; currentNum = 4'b0000;
    waitSlot(4'b0111);
    ticks(4);  check("row_c0", {1'b0, seg}, 8'h79);  check("row_an0", {4'h0, an}, 8'h0E);
    ticks(4);  check("row_c1", {1'b0, seg}, 8'h24);
    ticks(4);  check("row_c2", {1'b0, seg}, 8'h30);
    ticks(4);  check("row_c3", {1'b0, seg}, 8'h19);

    // Empty cells plus blink on cell 2 (edges 75, 91, 107 from release)
    currentRow = 16'h0300; currentNum = 4'b0100;
    waitSlot(4'b0111);
    ticks(4);  check("blink_c0_empty", {1'b0, seg}, 8'h7F);
    ticks(8);  check("blink_c2_on", {1'b0, seg}, 8'h30);
    ticks(16); check("blink_c2_off", {1'b0, seg}, 8'h7F);
    ticks(16); check("blink_c2_on2", {1'b0, seg}, 8'h30);

    // Deny dash with an extending second pulse
    currentRow = 16'h0005; currentNum = 4'b0001;
    waitSlot(4'b0111);
    denyPulse = 1'b1; ticks(1); denyPulse = 1'b0;
    ticks(3);  check("deny_p3", {1'b0, seg}, 8'h3F);
    ticks(16); check("deny_p19", {1'b0, seg}, 8'h3F);
    denyPulse = 1'b1; ticks(1); denyPulse = 1'b0;
    ticks(15); check("deny_p35_ext", {1'b0, seg}, 8'h3F);
    ticks(16); check("deny_p51_ext", {1'b0, seg}, 8'h3F);
    ticks(16); check("deny_done_blank", {1'b0, seg}, 8'h7F);
    ticks(16); check("deny_done_glyph", {1'b0, seg}, 8'h12);

    // Tearing: new row must wait for the next frame wrap
    currentRow = 16'h8888; currentNum = 4'b0000;
    ticks(4);  check("tear_c1_old", {1'b0, seg}, 8'h7F);
    ticks(8);  check("tear_c3_old", {1'b0, seg}, 8'h7F);
    ticks(4);  check("tear_c0_new", {1'b0, seg}, 8'h00);
    ticks(4);  check("tear_c1_new", {1'b0, seg}, 8'h00);

    // Reset in the middle of a dash cancels it
    currentNum = 4'b0001;
    waitSlot(4'b0111);
    denyPulse = 1'b1; ticks(1); denyPulse = 1'b0;
    ticks(3);  check("pre_rst_dash", {1'b0, seg}, 8'h3F);
    ticks(2);
    RST = 1'b1;
    ticks(1);
    check("mid_rst_seg", {1'b0, seg}, 8'h7F);
    check("mid_rst_an", {4'h0, an}, 8'h0F);
    ticks(1);
    RST = 1'b0;
    dashCount = 0;
    for (int i = 0; i < 40; i++) begin
      ticks(1);
      if (seg == 7'h3F) dashCount++;
    end
    check("no_dash_after_rst", dashCount[7:0], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
